car_collision_checker: RTL

- Per-frame pixel-accurate car-vs-car collision detector, directly downstream of the top-level opacity-map registers and position registers.
- On a start pulse it computes the overlap window of the two car sprites in map space and scans the two 1-bit opacity maps over that window, one pixel pair per cycle.
- Reports collision, first-hit coordinates and a saturating collision count. The game-control stage consumes the result on the next render frame.

---
 rtl/object_pkg.sv | 4 +
 rtl/sram_pkg.sv | 7 +
 rtl/collision_window.sv | 26 ++
 rtl/car_collision_checker.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/object_pkg.sv
// object_pkg: shared object-level types.
package object_pkg;
    typedef enum logic [1:0] {COL_IDLE, COL_LATCH, COL_SCAN, COL_DONE} CollisionState;
endpackage

// File: rtl/sram_pkg.sv
// sram_pkg: shared sprite and map geometry constants.
package sram_pkg;
    localparam int IMAGE_SIZE       = 8;
    localparam int MAP_H_WIDTH      = 11;
    localparam int MAP_V_WIDTH      = 10;
    localparam int IMAGE_COOR_WIDTH = $clog2(IMAGE_SIZE);
endpackage

// File: rtl/collision_window.sv
// collision_window: overlap flag and car1-local scan bounds for a car2-car1 offset.
module collision_window #(
    parameter int IMAGE_SIZE = 8,
    parameter int DX_WIDTH   = 12,
    parameter int DY_WIDTH   = 11
) (
    input  logic signed [DX_WIDTH-1:0]           i_dx,
    input  logic signed [DY_WIDTH-1:0]           i_dy,
    output logic                                 o_overlap,
    output logic        [$clog2(IMAGE_SIZE)-1:0] o_h_start,
    output logic        [$clog2(IMAGE_SIZE)-1:0] o_h_end,
    output logic        [$clog2(IMAGE_SIZE)-1:0] o_v_start,
    output logic        [$clog2(IMAGE_SIZE)-1:0] o_v_end
);
    localparam int CW = $clog2(IMAGE_SIZE);
    localparam logic signed [DX_WIDTH-1:0] SX = DX_WIDTH'(IMAGE_SIZE);
    localparam logic signed [DY_WIDTH-1:0] SY = DY_WIDTH'(IMAGE_SIZE);
    localparam logic [CW-1:0] LAST = CW'(IMAGE_SIZE - 1);

    assign o_overlap = (i_dx < SX) && (i_dx > -SX) && (i_dy < SY) && (i_dy > -SY);
    // Bounds are only meaningful under overlap, where the low bits alone are exact.
    assign o_h_start = (i_dx > 0) ? i_dx[CW-1:0] : '0;
    assign o_v_start = (i_dy > 0) ? i_dy[CW-1:0] : '0;
    assign o_h_end   = i_dx[DX_WIDTH-1] ? LAST + i_dx[CW-1:0] : LAST;
    assign o_v_end   = i_dy[DY_WIDTH-1] ? LAST + i_dy[CW-1:0] : LAST;
endmodule

// File: rtl/car_collision_checker.sv
// car_collision_checker: pixel-accurate car-vs-car overlap scan, one pixel pair per cycle.
// Define CAR_COLLISION_BBOX_EN to replace the scan with a bounding-box test.
module car_collision_checker
    import object_pkg::*;
#(
    parameter int IMAGE_SIZE  = sram_pkg::IMAGE_SIZE,
    parameter int MAP_H_WIDTH = sram_pkg::MAP_H_WIDTH,
    parameter int MAP_V_WIDTH = sram_pkg::MAP_V_WIDTH,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_start,
    input  logic signed [MAP_H_WIDTH-1:0]        i_car1_x,
    input  logic signed [MAP_V_WIDTH-1:0]        i_car1_y,
    input  logic signed [MAP_H_WIDTH-1:0]        i_car2_x,
    input  logic signed [MAP_V_WIDTH-1:0]        i_car2_y,
    input  logic i_car1_opacity_map [0:IMAGE_SIZE-1][0:IMAGE_SIZE-1],
    input  logic i_car2_opacity_map [0:IMAGE_SIZE-1][0:IMAGE_SIZE-1],
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_collision,
    output logic        [$clog2(IMAGE_SIZE)-1:0] o_hit_h,
    output logic        [$clog2(IMAGE_SIZE)-1:0] o_hit_v,
    output logic        [CNT_WIDTH-1:0]          o_collision_count
);
    localparam int CW = $clog2(IMAGE_SIZE);

    CollisionState state;
    logic signed [MAP_H_WIDTH-1:0] car1_x, car2_x;
    logic signed [MAP_V_WIDTH-1:0] car1_y, car2_y;
    logic signed [MAP_H_WIDTH:0]   dx;
    logic signed [MAP_V_WIDTH:0]   dy;
    logic                          overlap;
    logic [CW-1:0]                 h_start, h_end, v_start, v_end;
    logic                          fin, fin_col;
    logic [CW-1:0]                 fin_h, fin_v;

    assign dx = (MAP_H_WIDTH+1)'(car2_x) - (MAP_H_WIDTH+1)'(car1_x);
    assign dy = (MAP_V_WIDTH+1)'(car2_y) - (MAP_V_WIDTH+1)'(car1_y);

    collision_window #(
        .IMAGE_SIZE(IMAGE_SIZE),
        .DX_WIDTH  (MAP_H_WIDTH + 1),
        .DY_WIDTH  (MAP_V_WIDTH + 1)
    ) u_window (
        .i_dx     (dx),
        .i_dy     (dy),
        .o_overlap(overlap),
        .o_h_start(h_start),
        .o_h_end  (h_end),
        .o_v_start(v_start),
        .o_v_end  (v_end)
    );

`ifndef CAR_COLLISION_BBOX_EN
    logic [CW-1:0] h, v;
    logic          pair_hit;
    // Inside the window h-dx and v-dy are in range, so modular low-bit subtraction is exact.
    assign pair_hit = i_car1_opacity_map[h][v] & i_car2_opacity_map[h - dx[CW-1:0]][v - dy[CW-1:0]];
`endif

    always_comb begin
        fin     = 1'b0;
        fin_col = 1'b0;
        fin_h   = '0;
        fin_v   = '0;
        if (state == COL_LATCH) begin
`ifdef CAR_COLLISION_BBOX_EN
            fin     = 1'b1;
            fin_col = overlap;
            fin_h   = overlap ? h_start : '0;
            fin_v   = overlap ? v_start : '0;
`else
            fin     = !overlap;
`endif
        end
`ifndef CAR_COLLISION_BBOX_EN
        else if (state == COL_SCAN) begin
            fin     = pair_hit || (h == h_end && v == v_end);
            fin_col = pair_hit;
            fin_h   = pair_hit ? h : '0;
            fin_v   = pair_hit ? v : '0;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= COL_IDLE;
            car1_x            <= '0;
            car1_y            <= '0;
            car2_x            <= '0;
            car2_y            <= '0;
`ifndef CAR_COLLISION_BBOX_EN
            h                 <= '0;
            v                 <= '0;
`endif
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_collision       <= 1'b0;
            o_hit_h           <= '0;
            o_hit_v           <= '0;
            o_collision_count <= '0;
        end else if (fin) begin
            state       <= COL_DONE;
            o_done      <= 1'b1;
            o_collision <= fin_col;
            o_hit_h     <= fin_h;
            o_hit_v     <= fin_v;
            if (fin_col && !(&o_collision_count))
                o_collision_count <= o_collision_count + 1'b1;
        end else begin
            case (state)
                COL_IDLE: begin
                    if (i_start) begin
                        car1_x <= i_car1_x;
                        car1_y <= i_car1_y;
                        car2_x <= i_car2_x;
                        car2_y <= i_car2_y;
                        o_busy <= 1'b1;
                        state  <= COL_LATCH;
                    end
                end
`ifndef CAR_COLLISION_BBOX_EN
                COL_LATCH: begin
                    h     <= h_start;
                    v     <= v_start;
                    state <= COL_SCAN;
                end
                COL_SCAN: begin
                    if (h == h_end) begin
                        h <= h_start;
                        v <= v + 1'b1;
                    end else begin
                        h <= h + 1'b1;
                    end
                end
`endif
                default: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= COL_IDLE;
                end
            endcase
        end
    end
endmodule
